// File: rtl/bcd_digits_to_binary.sv
// Serial BCD digit stream (MSD first) to binary, using a multi-cycle shift-and-add (x10 = x8 + x2).
// Optional feature macro: RANGE_CHECK_EN (reject results above MAX_VALUE with a range_err strobe).
module bcd_digits_to_binary #(
    parameter int NUM_DIGITS = 2,
    parameter int VALUE_W    = 7,
    parameter int MAX_VALUE  = 59
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         digit,
    input  logic               digit_valid,
    output logic               digit_ready,
    input  logic               abort,
    output logic [VALUE_W-1:0] value,
    output logic               value_valid,
    output logic               digit_err,
    output logic               range_err
);

    typedef enum logic [1:0] {ST_ACCEPT, ST_MUL, ST_ADD, ST_DONE} state_t;

    localparam int            CNT_W    = 3;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

    state_t             state_q, state_d;
    logic [VALUE_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         dig_q, dig_d;
    logic [VALUE_W-1:0] value_q, value_d;
    logic               value_valid_q, value_valid_d;
    logic               digit_err_q, digit_err_d;
    logic               range_err_q, range_err_d;

`ifdef RANGE_CHECK_EN
    localparam logic [VALUE_W-1:0] MAX_V = VALUE_W'(MAX_VALUE);
`else
    logic unused_max_value;
    assign unused_max_value = ^MAX_VALUE;
`endif

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        dig_d         = dig_q;
        value_d       = value_q;
        value_valid_d = 1'b0;
        digit_err_d   = 1'b0;
        range_err_d   = 1'b0;

        // abort wins over everything, including a completion in DONE
        if (abort) begin
            state_d = ST_ACCEPT;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_ACCEPT: begin
                    if (digit_valid) begin
                        if (digit <= 4'd9) begin
                            dig_d   = digit;
                            state_d = ST_MUL;
                        end else begin
                            digit_err_d = 1'b1;
                            acc_d       = '0;
                            cnt_d       = '0;
                        end
                    end
                end
                ST_MUL: begin
                    acc_d   = (acc_q << 3) + (acc_q << 1);
                    state_d = ST_ADD;
                end
                ST_ADD: begin
                    acc_d   = acc_q + VALUE_W'(dig_q);
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == LAST_CNT) ? ST_DONE : ST_ACCEPT;
                end
                ST_DONE: begin
`ifdef RANGE_CHECK_EN
                    if (acc_q > MAX_V) begin
                        range_err_d = 1'b1;
                    end else begin
                        value_d       = acc_q;
                        value_valid_d = 1'b1;
                    end
`else
                    value_d       = acc_q;
                    value_valid_d = 1'b1;
`endif
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_ACCEPT;
                end
                default: state_d = ST_ACCEPT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_ACCEPT;
            acc_q         <= '0;
            cnt_q         <= '0;
            dig_q         <= '0;
            value_q       <= '0;
            value_valid_q <= 1'b0;
            digit_err_q   <= 1'b0;
            range_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            dig_q         <= dig_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            digit_err_q   <= digit_err_d;
            range_err_q   <= range_err_d;
        end
    end

    assign digit_ready = (state_q == ST_ACCEPT);
    assign value       = value_q;
    assign value_valid = value_valid_q;
    assign digit_err   = digit_err_q;
    assign range_err   = range_err_q;

endmodule

// File: tb/tb_bcd_digits_to_binary.sv
// Scoreboard bench: a 2-digit instance (default parameters) and a 4-digit instance (VALUE_W=14).
module tb_bcd_digits_to_binary;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  digit_a = '0, digit_b = '0;
    logic        dv_a = 1'b0, dv_b = 1'b0, ab_a = 1'b0, ab_b = 1'b0;
    logic        rdy_a, rdy_b;
    logic [6:0]  val_a;
    logic [13:0] val_b;
    logic        vv_a, de_a, re_a, vv_b, de_b, re_b;

    typedef struct {int kind; int val;} exp_t;   // kind: 0 value, 1 digit_err, 2 range_err
    exp_t q_a[$];
    exp_t q_b[$];
    int   n_pass = 0;
    int   n_checks = 0;
    int   mdl_acc[2];
    int   mdl_cnt[2];
    int   mdl_last[2];

    always #5 clk = ~clk;

    bcd_digits_to_binary #(.NUM_DIGITS(2), .VALUE_W(7), .MAX_VALUE(59)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .digit(digit_a), .digit_valid(dv_a), .digit_ready(rdy_a),
        .abort(ab_a), .value(val_a), .value_valid(vv_a), .digit_err(de_a), .range_err(re_a));

    bcd_digits_to_binary #(.NUM_DIGITS(4), .VALUE_W(14), .MAX_VALUE(9999)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .digit(digit_b), .digit_valid(dv_b), .digit_ready(rdy_b),
        .abort(ab_b), .value(val_b), .value_valid(vv_b), .digit_err(de_b), .range_err(re_b));

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int sel, input int kind, input int val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        if (sel == 0) q_a.push_back(e);
        else          q_b.push_back(e);
        if (kind == 0) mdl_last[sel] = val;
    endtask

    task automatic send(input int sel, input int d);
        int   n;
        logic rdy;
        n = 0;
        if (sel == 0) begin digit_a = 4'(d); dv_a = 1'b1; end
        else          begin digit_b = 4'(d); dv_b = 1'b1; end
        rdy = (sel == 0) ? rdy_a : rdy_b;
        while (rdy !== 1'b1 && n < 20) begin
            step(1);
            n++;
            rdy = (sel == 0) ? rdy_a : rdy_b;
        end
        if (n >= 20) check("ready_timeout", int'(rdy), 1);
        if (d > 9) begin
            push(sel, 1, 0);
            mdl_acc[sel] = 0;
            mdl_cnt[sel] = 0;
        end else begin
            mdl_acc[sel] = mdl_acc[sel] * 10 + d;
            mdl_cnt[sel]++;
            if (mdl_cnt[sel] == ((sel == 0) ? 2 : 4)) begin
`ifdef RANGE_CHECK_EN
                if (sel == 0 && mdl_acc[0] > 59) push(0, 2, 0);
                else
`endif
                push(sel, 0, mdl_acc[sel]);
                mdl_acc[sel] = 0;
                mdl_cnt[sel] = 0;
            end
        end
        step(1);
        dv_a = 1'b0;
        dv_b = 1'b0;
        rdy = (sel == 0) ? rdy_a : rdy_b;
        $display("digit sel=%0d d=%0d accepted, ready now %0b", sel, d, rdy);
        check("ready_after_transfer", int'(rdy), (d > 9) ? 1 : 0);
    endtask

    task automatic monitor(input int sel, input logic vv, input logic de, input logic re, input int val);
        int   k, ns;
        exp_t e;
        ns = int'(vv) + int'(de) + int'(re);
        if (ns > 1) check("strobe_exclusive", ns, 1);
        k = vv ? 0 : (de ? 1 : (re ? 2 : -1));
        if (k < 0) return;
        if ((sel == 0 && q_a.size() == 0) || (sel == 1 && q_b.size() == 0)) begin
            check("unexpected_strobe", k, -1);
            return;
        end
        if (sel == 0) e = q_a.pop_front();
        else          e = q_b.pop_front();
        $display("strobe sel=%0d kind=%0d value=%0d (expected kind=%0d value=%0d)", sel, k, val, e.kind, e.val);
        check("strobe_kind", k, e.kind);
        if (k == 0) check("strobe_value", val, e.val);
    endtask

    always @(negedge clk) if (rst_n) monitor(0, vv_a, de_a, re_a, int'(val_a));
    always @(negedge clk) if (rst_n) monitor(1, vv_b, de_b, re_b, int'(val_b));

    initial begin
        int n;
        mdl_acc  = '{0, 0};
        mdl_cnt  = '{0, 0};
        mdl_last = '{0, 0};
        #1;
        check("rst_value", int'(val_a), 0);
        check("rst_value_valid", int'(vv_a), 0);
        check("rst_digit_err", int'(de_a), 0);
        check("rst_range_err", int'(re_a), 0);
        check("rst_ready", int'(rdy_a), 1);
        check("rst_value_b", int'(val_b), 0);
        step(2);
        rst_n = 1'b1;
        step(1);

        // 47 with latency check
        send(0, 4);
        send(0, 7);
        step(2);
        check("latency_early", int'(vv_a), 0);
        step(1);
        check("latency_on", int'(vv_a), 1);
        check("value_47", int'(val_a), 47);
        step(1);

`ifdef RANGE_CHECK_EN
        send(0, 9);
        send(0, 9);
        step(4);
        check("range_value_hold", int'(val_a), 47);
        send(0, 5);
        send(0, 9);
        step(4);
        check("value_59", int'(val_a), 59);
`endif

        // non-BCD digit, then 12
        send(0, 12);
        step(1);
        check("value_hold_after_err", int'(val_a), mdl_last[0]);
        send(0, 1);
        send(0, 2);
        step(4);
        check("value_12", int'(val_a), 12);

        // abort during MUL discards the 5
        send(0, 5);
        ab_a = 1'b1;
        mdl_acc[0] = 0;
        mdl_cnt[0] = 0;
        step(1);
        ab_a = 1'b0;
        check("ready_after_abort", int'(rdy_a), 1);
        send(0, 0);
        send(0, 8);
        step(4);
        check("value_08", int'(val_a), 8);

        // four-digit instance
        send(1, 2); send(1, 0); send(1, 9); send(1, 9);
        step(4);
        check("value_2099", int'(val_b), 2099);
        send(1, 9); send(1, 9); send(1, 9); send(1, 9);
        step(4);
        check("value_9999", int'(val_b), 9999);

        // async reset while in ADD
        send(0, 3);
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_value", int'(val_a), 0);
        check("async_rst_ready", int'(rdy_a), 1);
        check("async_rst_value_b", int'(val_b), 0);
        mdl_acc = '{0, 0};
        mdl_cnt = '{0, 0};
        #1;
        rst_n = 1'b1;
        step(1);
        check("ready_after_rst", int'(rdy_a), 1);
        send(0, 1);
        send(0, 0);
        step(4);
        check("value_10", int'(val_a), 10);

        n = 0;
        while ((q_a.size() + q_b.size()) != 0 && n < 50) begin
            step(1);
            n++;
        end
        check("scoreboard_drained", q_a.size() + q_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
